// File: rtl/miss_port_arbiter_pkg.sv
// Shared types for the miss-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   arb_req_t   : memory command {we, addr, wdata} at the default 32/32 widths
package miss_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/priority_encoder_parameterized.sv
// Highest-index-wins priority encoder.
//   req_vec : request bit vector
//   idx     : index of the highest set bit (0 when none set)
//   valid   : any bit set
module priority_encoder_parameterized #(
  parameter int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |req_vec;
    // ascending scan, last hit wins -> highest set index
    for (int i = 0; i < WIDTH; i++) begin
      if (req_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/miss_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ miss/writeback
// requesters. One transaction in flight: accept, issue, wait for completion,
// route the response back to the owner.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : per-requester valid/we/addr/wdata; req_ready one-hot accept
//   resp_valid/rdata  : one-hot one-cycle completion strobe + shared data
//   mem_*             : downstream command handshake and completion
//   busy, owner       : transaction in flight, current/last granted index
module miss_port_arbiter
  import miss_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_rdata,
  output logic                                 mem_valid,
  input  logic                                 mem_ready,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic                                 busy,
  output logic [$clog2(NUM_REQ)-1:0]           owner
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // command register sized by this instance's widths
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  generate
    if (NUM_REQ < 2) begin : g_bad_num_req
      $fatal(1, "miss_port_arbiter: NUM_REQ must be >= 2");
    end
  endgenerate

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   last_grant, winner;
  logic [NUM_REQ-1:0] mask, masked, enc_in, grant_oh, owner_oh;
  logic               any_req, accept;
  cmd_t               cmd;

  // ---------------- winner selection ----------------
  // Only indices below last_grant are eligible first; if none of those
  // request, fall back to the raw vector (wrap to the highest index).
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) mask[i] = (last_grant > IDX_W'(i));
  end

  assign masked = req_valid & mask;
  assign enc_in = (|masked) ? masked : req_valid;

  priority_encoder_parameterized #(.WIDTH(NUM_REQ)) u_enc (
    .req_vec (enc_in),
    .idx     (winner),
    .valid   (any_req)
  );

  always_comb begin
    grant_oh = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (winner == IDX_W'(i));
      owner_oh[i] = (owner  == IDX_W'(i));
    end
  end

  // no acceptance while reset is asserted, even though state reads IDLE
  assign accept    = rst_n && (state == IDLE) && any_req;
  assign req_ready = accept ? grant_oh : '0;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)    state_nxt = ISSUE;
      ISSUE:   if (mem_ready)  state_nxt = WAIT;
      WAIT:    if (mem_rvalid) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // ---------------- command / response registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= '0;
      owner      <= '0;
      cmd        <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      if (accept) begin
        last_grant <= winner;
        owner      <= winner;
        cmd        <= '{we: req_we[winner], addr: req_addr[winner], wdata: req_wdata[winner]};
      end
      // completions outside WAIT are stray and dropped
      if (state == WAIT && mem_rvalid) begin
        resp_valid <= owner_oh;
        resp_rdata <= mem_rdata;
      end
    end
  end

  assign mem_valid = (state == ISSUE);
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_miss_port_arbiter.sv
// Directed bench for miss_port_arbiter (NUM_REQ=4): reset, rotation,
// partial rotation, single read latency, backpressure, reset mid-flight.
module tb_miss_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid, req_we, req_ready, resp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]      resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_addr;
  logic               mem_valid, mem_ready, mem_we, mem_rvalid, busy;
  logic [1:0]         owner;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  miss_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // inputs are driven 2 time units after the rising edge
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // one full transaction with a 1-cycle memory: grant, issue, complete
  task automatic xact(input int g, input logic [31:0] rd);
    mem_rvalid = 1'b0;
    #1;
    check("grant", req_ready, 64'(1) << g);
    nxt(); #1;
    check("issue_rdy0", req_ready, 0);
    check("issue_valid", mem_valid, 1);
    check("issue_addr", mem_addr, req_addr[g]);
    check("issue_we", mem_we, req_we[g]);
    check("owner", owner, g);
    nxt();
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    #1;
    check("wait_valid0", mem_valid, 0);
    check("wait_rdy0", req_ready, 0);
    nxt();
    mem_rvalid = 1'b0;
    #1;
    check("resp_valid", resp_valid, 64'(1) << g);
    check("resp_rdata", resp_rdata, rd);
  endtask

  initial begin
    int order [6];
    order = '{3, 2, 1, 0, 3, 2};

    rst_n        = 1'b0;
    req_valid    = 4'hF;
    req_we       = 4'b0001;
    req_addr[0]  = 32'h40;
    req_addr[1]  = 32'h2000;
    req_addr[2]  = 32'h100;
    req_addr[3]  = 32'h3000;
    req_wdata[0] = 32'h1234;
    req_wdata[1] = 32'hAAAA0001;
    req_wdata[2] = 32'hAAAA0002;
    req_wdata[3] = 32'hAAAA0003;
    mem_ready    = 1'b1;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;

    // ---- reset held 3 cycles with every request active ----
    for (int c = 0; c < 3; c++) begin
      nxt(); #1;
      check("rst_ready", req_ready, 0);
    end
    check("rst_mem_valid", mem_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_owner", owner, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // ---- rotation, all active: 3,2,1,0,3,2 (first grant after reset = 3) ----
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) xact(order[k], 32'hA0 + k);

    // ---- partial rotation: after 2, only 3 and 1 pend -> 1 then 3 ----
    req_valid = 4'b1010;
    xact(1, 32'hB1);
    xact(3, 32'hB3);

    // ---- single read from requester 2, completion 3 cycles after handshake ----
    req_valid = 4'b0100;
    #1;
    check("sr_grant", req_ready, 4'b0100);
    nxt();
    req_valid = 4'b0000;
    #1;
    check("sr_mem_valid", mem_valid, 1);
    check("sr_mem_addr", mem_addr, 32'h100);
    check("sr_mem_we", mem_we, 0);
    nxt(); #1;                                   // handshake done, WAIT
    check("sr_busy", busy, 1);
    check("sr_no_resp", resp_valid, 0);
    nxt();
    nxt();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    nxt();
    mem_rvalid = 1'b0;
    #1;
    check("sr_resp_valid", resp_valid, 4'b0100);
    check("sr_resp_rdata", resp_rdata, 32'hDEADBEEF);
    nxt(); #1;
    check("sr_resp_pulse", resp_valid, 0);

    // ---- backpressure: write from requester 0, mem_ready low 5 cycles ----
    mem_ready = 1'b0;
    req_valid = 4'b1001;
    #1;
    check("bp_grant", req_ready, 4'b0001);
    for (int c = 1; c <= 5; c++) begin
      nxt();
      req_valid  = 4'b1000;
      mem_rvalid = (c == 3);                     // stray completion during ISSUE
      mem_rdata  = 32'hBAD0BAD0;
      #1;
      check("bp_valid", mem_valid, 1);
      check("bp_addr", mem_addr, 32'h40);
      check("bp_wdata", mem_wdata, 32'h1234);
      check("bp_we", mem_we, 1);
      check("bp_ready0", req_ready, 0);
      check("bp_resp0", resp_valid, 0);
    end
    nxt();
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    #1;
    check("bp_still_issue", mem_valid, 1);
    nxt();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555;
    #1;
    check("bp_wait", mem_valid, 0);
    nxt();
    mem_rvalid = 1'b0;
    #1;
    // response of this write coincides with acceptance of requester 3
    check("bp_resp", resp_valid, 4'b0001);
    check("bp_resp_rdata", resp_rdata, 32'h5555);
    check("bp_next_grant", req_ready, 4'b1000);

    // ---- reset while in WAIT, then a late completion ----
    nxt();
    req_valid = 4'b0000;                          // ISSUE for requester 3
    nxt(); #1;                                    // WAIT
    check("mr_busy", busy, 1);
    rst_n     = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("mr_rst_ready", req_ready, 0);
    nxt();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFEEDF00D;
    #1;
    check("mr_idle", busy, 0);
    check("mr_no_resp", resp_valid, 0);
    check("mr_owner_rst", owner, 0);
    check("mr_grant_high", req_ready, 4'b0100);
    nxt();
    mem_rvalid = 1'b0;
    #1;
    check("mr_late_ignored", resp_valid, 0);
    check("mr_owner", owner, 2);
    check("mr_issue", mem_valid, 1);
    check("mr_issue_addr", mem_addr, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/miss_port_arbiter.md
# miss_port_arbiter

Round-robin arbiter that shares a single downstream memory port among `NUM_REQ` cache miss/writeback requesters (banks or MSHRs). It accepts one request at a time, holds the port until that transaction's response returns, then routes the response back to the owning requester. Winner selection uses the existing `priority_encoder_parameterized` helper on a rotated request mask.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; must be ≥ 2 (elaboration `$fatal` otherwise).
- `ADDR_WIDTH`, 32, request/memory address width.
- `DATA_WIDTH`, 32, write and read data width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request pending; held until accepted.
- `req_we` in `NUM_REQ`: 1 = write, 0 = read.
- `req_addr` in `NUM_REQ`×`ADDR_WIDTH`: per-requester address.
- `req_wdata` in `NUM_REQ`×`DATA_WIDTH`: per-requester write data.
- `req_ready` out `NUM_REQ`: one-hot acceptance strobe, combinational.
- `resp_valid` out `NUM_REQ`: one-hot, one-cycle completion strobe, registered.
- `resp_rdata` out `DATA_WIDTH`: shared response data, valid with `resp_valid`.
- `mem_valid` out 1, `mem_ready` in 1: memory command handshake.
- `mem_we` out 1, `mem_addr` out `ADDR_WIDTH`, `mem_wdata` out `DATA_WIDTH`: command fields, registered.
- `mem_rvalid` in 1, `mem_rdata` in `DATA_WIDTH`: completion. Reads and writes both complete with one `mem_rvalid` pulse.
- `busy` out 1: high in ISSUE and WAIT.
- `owner` out `$clog2(NUM_REQ)`: index of current/last granted requester.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any `req_valid` is high, compute the winner and assert `req_ready[winner]` the same cycle.
  - Capture the winner's `we/addr/wdata` into the command registers.
  - Set `owner`, `last_grant` ← winner; go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE**
  - `mem_valid`=1 with the captured fields, held stable until `mem_ready`.
  - On `mem_valid && mem_ready`, go to WAIT.
- **WAIT**
  - On `mem_rvalid`, register `mem_rdata` into `resp_rdata` and set `resp_valid[owner]` for the next cycle.
  - Go to IDLE.
- **Winner selection**
  - `mask` = bits strictly below `last_grant`.
  - If `req_valid & mask` is nonzero, encode the masked vector; otherwise encode raw `req_valid`.
  - Result: descending rotation from `last_grant`−1 down to 0, then wrap to the highest index.
- `req_ready` is 0 outside IDLE; requesters keep `req_valid` asserted while waiting.
- `mem_rvalid` in IDLE or ISSUE is a protocol violation: ignored, no state change.
- `resp_valid` of transaction k and `req_ready` of transaction k+1 may coincide (IDLE cycle).

## Timing
- Reset values:
  - state IDLE.
  - `last_grant`=0, so the first grant goes to the highest active index.
  - `owner`=0, `mem_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `busy`=0.
  - `req_ready`=0, since state is IDLE and no request can be accepted during reset.
- Acceptance at cycle T implies `mem_valid` high from T+1.
- With `mem_ready` high at T+1, the earliest `mem_rvalid` is T+2; `resp_valid` is then at T+3, where the next acceptance may also occur.
- Minimum occupancy: 3 cycles per transaction.
- Reset during ISSUE/WAIT: next cycle is IDLE.
  - The in-flight transaction is dropped and no `resp_valid` is produced.
  - A late `mem_rvalid` is ignored.
  - `last_grant` returns to 0.
- Starvation bound: a continuously requesting input is granted within `NUM_REQ` grants.

## Structure
- Package `miss_arb_pkg`:
  - `arb_state_e` enum (IDLE, ISSUE, WAIT).
  - Request struct typedef `{we, addr, wdata}` parameterized via localparam widths, default 32/32.
- One sub-module: `priority_encoder_parameterized #(.WIDTH(NUM_REQ))`, single instance fed by a mux selecting the masked or raw vector.
- Mask generation, FSM and command/response registers stay in this module.

## Test plan
Use `NUM_REQ`=4.
- **Reset:** hold `rst_n`=0 for 3 cycles with all `req_valid`=1 → all outputs 0, `req_ready`=0; after release, first grant is index 3.
- **Single read:** `req_valid[2]`, addr 0x100, read; `mem_ready`=1; `mem_rvalid` 3 cycles after handshake with 0xDEADBEEF → `req_ready[2]` at T, `mem_valid` with `mem_addr`=0x100 at T+1, `resp_valid`=4'b0100 with `resp_rdata`=0xDEADBEEF one cycle after `mem_rvalid`.
- **Rotation, all active:** all four requests held continuously, 1-cycle memory → grant order 3,2,1,0,3,2; each grant exactly one `req_ready` pulse.
- **Rotation, partial:** after granting 2, only requests 3 and 1 pending → 1 granted next, then 3.
- **Backpressure:** `mem_ready` low for 5 cycles in ISSUE with a write (addr 0x40, data 0x1234) → `mem_valid`, `mem_addr`, `mem_wdata` stable all 5 cycles; `req_ready`=0 while other requests pend; `mem_rvalid` injected during ISSUE is ignored.
- **Reset mid-transaction:** `rst_n` low one cycle in WAIT, then `mem_rvalid` → state IDLE, no `resp_valid`, next grant is the highest active index.
